sprite_draw_engine: RTL and testbench
=====================================

// Module: sprite_draw_engine
// PURPOSE
//  Consumer stage of the sprite command FIFO. Pops one 43-bit command at a time and executes it.
//  DRAW renders an 8x8 1-bpp sprite from sprite ROM into the framebuffer in a single colour, clipped to the screen.
//  CLEAR fills the whole framebuffer with one colour.
//  Sits between the sprite command FIFO and the framebuffer write port.
// PARAMETERS
//  SCREEN_W  640  visible width in pixels
//  SCREEN_H  480  visible height in pixels
//  FB_AW     19   framebuffer address width; must satisfy SCREEN_W*SCREEN_H <= 2**FB_AW
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      reset, synchronous, active-low
//  cmd_empty  in   1      FIFO has no command
//  curr_cmd   in   43     command at FIFO head (combinational from FIFO)
//  cmd_read   out  1      pop strobe to FIFO, 1-cycle pulse
//  rom_addr   out  11     sprite ROM address = {sprite_id, row[2:0]}
//  rom_data   in   8      sprite row bitmap, valid 1 cycle after rom_addr
//  fb_we      out  1      framebuffer write request
//  fb_addr    out  FB_AW  pixel address = y*SCREEN_W + x
//  fb_data    out  8      pixel colour
//  fb_ready   in   1      framebuffer accepts the write this cycle
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Command fields:
//   [42:40] opcode: 000 NOP, 001 DRAW, 010 CLEAR, others treated as NOP
//   [39:32] sprite_id; [31:22] x; [21:13] y; [12:5] colour; [4:0] reserved, ignored
//  Reset (rst_n low at a clk edge):
//   state=IDLE; cmd_read=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0, busy=0.
//   Applies mid-command too: the command in progress is abandoned with no further writes.
//   A command already popped is lost.
//  IDLE:
//   If !cmd_empty, pulse cmd_read for exactly one cycle and latch curr_cmd in that same cycle.
//   Next state: DRAW -> FETCH (row=0); CLEAR -> CLR (addr=0); NOP -> stays IDLE.
//   Never asserts cmd_read while cmd_empty=1, or in any state other than IDLE.
//  FETCH:
//   Drive rom_addr={sprite_id,row}. Go to LOAD.
//  LOAD:
//   Latch rom_data into the row register; col=0. Go to PIXEL.
//  PIXEL:
//   Bit order: col c uses row-register bit [7-c] (MSB = leftmost pixel).
//   Pixel position: px=x+c, py=y+row, computed 11 bits wide, no wrap.
//   Write the pixel only if the bit is 1 and px<SCREEN_W and py<SCREEN_H.
//    For such a pixel, fb_we=1 with fb_addr=py*SCREEN_W+px and fb_data=colour.
//   Hold fb_we/fb_addr/fb_data stable until the cycle fb_ready=1; the write completes in that cycle.
//   A skipped pixel (bit 0 or clipped) costs exactly 1 cycle with fb_we=0.
//   After col 7: if row==7 go to IDLE, else row+1 and go to FETCH.
//  CLR:
//   fb_we=1, fb_data=colour, fb_addr=addr.
//   On fb_ready: if addr==SCREEN_W*SCREEN_H-1 go to IDLE, else addr+1.
//  fb_we is registered: never asserted in IDLE, FETCH or LOAD.
//  Latency:
//   Pop -> first rom_addr: 1 cycle. Pop -> earliest fb_we: 3 cycles.
//   DRAW with fb_ready tied high: 8*(2+8) = 80 cycles.
//  If cmd_empty toggles while the engine is busy, it is ignored until IDLE.
//  Back-to-back commands: the next pop occurs on the first IDLE cycle.
// TESTING
//  1. Reset: hold rst_n=0 two cycles with cmd_empty=0
//     -> cmd_read=0, fb_we=0, busy=0.
//     Release -> cmd_read pulses on the first cycle.
//  2. DRAW id=3, x=10, y=20, colour=0x2A; ROM returns 0x81 for every row; fb_ready=1
//     -> exactly 16 writes, data 0x2A, at addresses (20+r)*640+10 and +17 for r=0..7.
//     First rom_addr=0x018. Done 80 cycles after the pop.
//  3. Clip: DRAW x=636, y=476, ROM=0xFF
//     -> only 16 writes, px 636..639 and py 476..479; no address >= 307200.
//  4. Backpressure: test 2 with fb_ready low 3 cycles per write
//     -> fb_addr/fb_data held stable, same 16 writes in the same order.
//  5. CLEAR colour=0x07 with SCREEN_W=4, SCREEN_H=2
//     -> writes addr 0..7 with data 0x07, then IDLE.
//     Also: NOP/opcode 111 pops with zero writes.
//  6. Reset asserted during PIXEL of row 3
//     -> fb_we=0 next cycle, IDLE; the queued next command is popped after release.

Source files
------------

// File: rtl/sprite_draw_engine.sv
// Sprite command consumer: pops DRAW/CLEAR commands from the command FIFO and
// turns them into framebuffer pixel writes (8x8 1-bpp sprites, clipped; full clears).
module sprite_draw_engine #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int FB_AW    = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_empty,
  input  logic [42:0]      curr_cmd,
  output logic             cmd_read,
  output logic [10:0]      rom_addr,
  input  logic [7:0]       rom_data,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_data,
  input  logic             fb_ready,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PIXEL, CLR} state_t;

  localparam logic [2:0]       OP_DRAW   = 3'b001;
  localparam logic [2:0]       OP_CLEAR  = 3'b010;
  localparam logic [10:0]      W_LIM     = 11'(SCREEN_W);
  localparam logic [10:0]      H_LIM     = 11'(SCREEN_H);
  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(SCREEN_W * SCREEN_H - 1);

  state_t             state_q, state_d;
  logic [7:0]         sprite_id_q, sprite_id_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic [7:0]         colour_q, colour_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [7:0]         bits_q, bits_d;
  logic [10:0]        rom_addr_q, rom_addr_d;
  logic               fb_we_q, fb_we_d;
  logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
  logic [7:0]         fb_data_q, fb_data_d;

  // Reserved command bits carry no meaning for this stage.
  logic unused_bits;
  assign unused_bits = ^curr_cmd[4:0];

  // Pixel evaluation is done one cycle ahead so the framebuffer port is driven from flops:
  // in LOAD it looks at column 0 of the fresh ROM row, in PIXEL at the next column.
  logic [7:0]       src_bits;
  logic [2:0]       eval_col;
  logic [10:0]      px, py;
  logic             pix_on;
  logic [FB_AW-1:0] pix_addr;

  always_comb begin
    src_bits = (state_q == LOAD) ? rom_data : bits_q;
    eval_col = (state_q == LOAD) ? 3'd0 : col_q + 3'd1;
    px       = 11'(x_q) + 11'(eval_col);
    py       = 11'(y_q) + 11'(row_q);
    pix_on   = src_bits[3'd7 - eval_col] && (px < W_LIM) && (py < H_LIM);
    pix_addr = FB_AW'(32'(py) * 32'(SCREEN_W) + 32'(px));
  end

  // NOTE: the pop strobe is gated by rst_n so the FIFO never loses a command while the engine is held in reset.
  assign cmd_read = rst_n && (state_q == IDLE) && !cmd_empty;
  assign busy     = (state_q != IDLE);
  assign rom_addr = rom_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    sprite_id_d = sprite_id_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    row_d       = row_q;
    col_d       = col_q;
    bits_d      = bits_q;
    rom_addr_d  = rom_addr_q;
    fb_we_d     = fb_we_q;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;

    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          sprite_id_d = curr_cmd[39:32];
          x_d         = curr_cmd[31:22];
          y_d         = curr_cmd[21:13];
          colour_d    = curr_cmd[12:5];
          case (curr_cmd[42:40])
            OP_DRAW: begin
              state_d    = FETCH;
              row_d      = 3'd0;
              rom_addr_d = {curr_cmd[39:32], 3'd0};
            end
            OP_CLEAR: begin
              state_d   = CLR;
              fb_we_d   = 1'b1;
              fb_addr_d = '0;
              fb_data_d = curr_cmd[12:5];
            end
            default: ;
          endcase
        end
      end

      FETCH: state_d = LOAD;

      LOAD: begin
        state_d   = PIXEL;
        bits_d    = rom_data;
        col_d     = 3'd0;
        fb_we_d   = pix_on;
        fb_addr_d = pix_addr;
        fb_data_d = colour_q;
      end

      PIXEL: begin
        // A pending write holds everything until accepted; a skipped pixel moves on at once.
        if (!fb_we_q || fb_ready) begin
          if (col_q == 3'd7) begin
            fb_we_d = 1'b0;
            if (row_q == 3'd7) begin
              state_d = IDLE;
            end else begin
              state_d    = FETCH;
              row_d      = row_q + 3'd1;
              rom_addr_d = {sprite_id_q, row_q + 3'd1};
            end
          end else begin
            col_d     = col_q + 3'd1;
            fb_we_d   = pix_on;
            fb_addr_d = pix_addr;
          end
        end
      end

      CLR: begin
        if (fb_ready) begin
          if (fb_addr_q == LAST_ADDR) begin
            state_d = IDLE;
            fb_we_d = 1'b0;
          end else begin
            fb_addr_d = fb_addr_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always loaded before the FSM reads them.
  always_ff @(posedge clk) begin
    sprite_id_q <= sprite_id_d;
    x_q         <= x_d;
    y_q         <= y_d;
    colour_q    <= colour_d;
    row_q       <= row_d;
    col_q       <= col_d;
    bits_q      <= bits_d;
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: FIFO/ROM/framebuffer models around a full-size
// instance plus a tiny 4x2 instance for the clear sequence.
module tb_sprite_draw_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b0;
  logic        cmd_empty = 1'b1;
  logic [42:0] curr_cmd  = '0;
  logic        cmd_read;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data  = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready  = 1'b1;
  logic        busy;

  logic        s_cmd_empty = 1'b1;
  logic [42:0] s_curr_cmd  = '0;
  logic        s_cmd_read;
  logic [10:0] s_rom_addr;
  logic [7:0]  s_rom_data  = '0;
  logic        s_fb_we;
  logic [2:0]  s_fb_addr;
  logic [7:0]  s_fb_data;
  logic        s_fb_ready  = 1'b1;
  logic        s_busy;

  sprite_draw_engine dut (
    .clk(clk), .rst_n(rst_n), .cmd_empty(cmd_empty), .curr_cmd(curr_cmd),
    .cmd_read(cmd_read), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_ready(fb_ready), .busy(busy)
  );

  sprite_draw_engine #(.SCREEN_W(4), .SCREEN_H(2), .FB_AW(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .cmd_empty(s_cmd_empty), .curr_cmd(s_curr_cmd),
    .cmd_read(s_cmd_read), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .fb_we(s_fb_we), .fb_addr(s_fb_addr), .fb_data(s_fb_data),
    .fb_ready(s_fb_ready), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Environment models
  logic [42:0] fifo_q[$];
  bit          pop_pend  = 1'b0;
  int          pops      = 0;
  bit          bp_mode   = 1'b0;
  int          stall_cnt = 0;
  logic [7:0]  rom_val   = 8'h00;
  logic [7:0]  exp_id    = 8'h00;

  logic [18:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [18:0] exp_a[$];
  logic [7:0]  exp_d;

  bit          stall_prev = 1'b0;
  logic [18:0] prev_a;
  logic [7:0]  prev_d;
  int          stalls    = 0;
  int          hold_viol = 0;
  int          rd_viol   = 0;
  int          oob       = 0;

  always @(posedge clk) rom_data <= (rom_addr[10:3] == exp_id) ? rom_val : 8'h00;

  always @(negedge clk) begin
    if (cmd_read) begin
      pop_pend = 1'b1;
      if (cmd_empty) rd_viol++;
    end
    if (fb_we && fb_ready) begin
      wr_a.push_back(fb_addr);
      wr_d.push_back(fb_data);
    end
    if (fb_we && fb_addr >= 19'd307200) oob++;
    if (stall_prev && (!fb_we || fb_addr !== prev_a || fb_data !== prev_d)) hold_viol++;
    stall_prev = fb_we && !fb_ready;
    if (stall_prev) stalls++;
    prev_a = fb_addr;
    prev_d = fb_data;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      void'(fifo_q.pop_front());
      pop_pend = 1'b0;
      pops++;
    end
    cmd_empty = (fifo_q.size() == 0);
    curr_cmd  = cmd_empty ? 43'd0 : fifo_q[0];
    if (bp_mode && fb_we && stall_cnt < 3) begin
      fb_ready = 1'b0;
      stall_cnt++;
    end else begin
      fb_ready  = 1'b1;
      stall_cnt = 0;
    end
  end

  function automatic logic [42:0] mk(input logic [2:0] op, input logic [7:0] id,
                                     input logic [9:0] x, input logic [8:0] y,
                                     input logic [7:0] colour);
    return {op, id, x, y, colour, 5'b0};
  endfunction

  // Called at a negedge; returns at the negedge of the pop cycle.
  task automatic wait_pop(input string tag);
    int t = 0;
    while (!cmd_read && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(cmd_read), 32'd1);
  endtask

  task automatic run_cmd(input logic [42:0] c, output int cyc, output int first_we,
                         output logic [10:0] first_rom);
    wr_a.delete();
    wr_d.delete();
    cyc       = 0;
    first_we  = 0;
    first_rom = '0;
    fifo_q.push_back(c);
    wait_pop("pop_seen");
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1) first_rom = rom_addr;
      if (fb_we && first_we == 0) first_we = k;
      if (!busy) break;
      cyc++;
    end
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_count"}, 32'(wr_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_a[i]), 32'(exp_a[i]));
      check({tag, "_data"}, 32'(wr_d[i]), 32'(exp_d));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, fw, base, n, t;
    logic [10:0] fr;
    bit         found;

    // 1. reset held two cycles with a command waiting
    fifo_q.push_back(mk(3'b000, 8'd0, 10'd0, 9'd0, 8'd0));
    repeat (2) begin
      @(negedge clk);
      check("rst_cmd_read", 32'(cmd_read), 32'd0);
      check("rst_fb_we", 32'(fb_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_read", 32'(cmd_read), 32'd1);
    repeat (2) @(negedge clk);

    // 2. DRAW id=3 at (10,20), ROM row 0x81
    exp_id  = 8'd3;
    rom_val = 8'h81;
    exp_a.delete();
    for (int r = 0; r < 8; r++) begin
      exp_a.push_back(19'((20 + r) * 640 + 10));
      exp_a.push_back(19'((20 + r) * 640 + 17));
    end
    exp_d = 8'h2A;
    run_cmd(mk(3'b001, 8'd3, 10'd10, 9'd20, 8'h2A), cyc, fw, fr);
    check("t2_busy_cycles", 32'(cyc), 32'd80);
    check("t2_first_we", 32'(fw), 32'd3);
    check("t2_first_rom", 32'(fr), 32'h018);
    cmp_writes("t2");

    // 3. clipping at the bottom-right corner
    exp_id  = 8'd5;
    rom_val = 8'hFF;
    oob     = 0;
    exp_a.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_a.push_back(19'((476 + r) * 640 + 636 + c));
    exp_d = 8'h55;
    run_cmd(mk(3'b001, 8'd5, 10'd636, 9'd476, 8'h55), cyc, fw, fr);
    check("t3_busy_cycles", 32'(cyc), 32'd80);
    check("t3_no_oob", 32'(oob), 32'd0);
    cmp_writes("t3");

    // 4. test 2 again with three stall cycles per write
    exp_id    = 8'd3;
    rom_val   = 8'h81;
    exp_a.delete();
    for (int r = 0; r < 8; r++) begin
      exp_a.push_back(19'((20 + r) * 640 + 10));
      exp_a.push_back(19'((20 + r) * 640 + 17));
    end
    exp_d     = 8'h2A;
    bp_mode   = 1'b1;
    stalls    = 0;
    hold_viol = 0;
    run_cmd(mk(3'b001, 8'd3, 10'd10, 9'd20, 8'h2A), cyc, fw, fr);
    bp_mode   = 1'b0;
    check("t4_busy_cycles", 32'(cyc), 32'd128);
    check("t4_stalls", 32'(stalls), 32'd48);
    check("t4_hold_stable", 32'(hold_viol), 32'd0);
    cmp_writes("t4");

    // NOP and undefined opcode pop without writing
    base = pops;
    run_cmd(mk(3'b000, 8'd1, 10'd1, 9'd1, 8'h11), cyc, fw, fr);
    check("nop_busy", 32'(cyc), 32'd0);
    check("nop_writes", 32'(wr_a.size()), 32'd0);
    run_cmd(mk(3'b111, 8'd1, 10'd1, 9'd1, 8'h11), cyc, fw, fr);
    check("op7_busy", 32'(cyc), 32'd0);
    check("op7_writes", 32'(wr_a.size()), 32'd0);
    @(negedge clk);
    check("nop_pops", 32'(pops - base), 32'd2);

    // 5. CLEAR on the 4x2 instance
    s_curr_cmd  = mk(3'b010, 8'd0, 10'd0, 9'd0, 8'h07);
    s_cmd_empty = 1'b0;
    t = 0;
    while (!s_cmd_read && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("t5_pop", 32'(s_cmd_read), 32'd1);
    @(negedge clk);
    s_cmd_empty = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (s_fb_we && s_fb_ready) begin
        check("t5_addr", 32'(s_fb_addr), 32'(n));
        check("t5_data", 32'(s_fb_data), 32'h07);
        n++;
      end
      if (!s_busy) break;
      @(negedge clk);
    end
    check("t5_count", 32'(n), 32'd8);
    check("t5_idle_we", 32'(s_fb_we), 32'd0);
    check("t5_idle_busy", 32'(s_busy), 32'd0);

    // 6. reset during row 3 of a DRAW, with a NOP queued behind it
    exp_id  = 8'd3;
    rom_val = 8'h81;
    fifo_q.push_back(mk(3'b001, 8'd3, 10'd10, 9'd20, 8'h2A));
    wait_pop("t6_pop");
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 19'(23 * 640 + 10)) found = 1'b1;
    end
    check("t6_reached_row3", 32'(found), 32'd1);
    rst_n = 1'b0;
    fifo_q.push_back(mk(3'b000, 8'd0, 10'd0, 9'd0, 8'd0));
    @(negedge clk);
    base = wr_a.size();
    check("t6_we_after_rst", 32'(fb_we), 32'd0);
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    check("t6_no_pop_in_rst", 32'(cmd_read), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t6_pop_after_rel", 32'(cmd_read), 32'd1);
    repeat (4) @(negedge clk);
    check("t6_no_more_writes", 32'(wr_a.size()), 32'(base));
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_fifo_drained", 32'(fifo_q.size()), 32'd0);

    check("no_pop_when_empty", 32'(rd_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
